wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Owns the single register-file write port (WE3/AD3/WD3) and shares it between the in-order pipeline writeback and a
//  long-latency unit (mul/div, slow load) that returns results out of band. Holds a scoreboard of registers with
//  results still in flight and raises stall to decode on RAW/WAW hazards or write-port congestion.
//  Sits between decode/writeback and reg_file; reg_file's WE3/AD3/WD3 connect only to this block.
// PARAMETERS
//  DATA_WIDTH    32  register data width
//  ADDR_WIDTH    5   register index width (2**ADDR_WIDTH registers; index 0 hardwired zero)
//  FIFO_DEPTH    2   long-unit result buffer entries, power of two, >=2
//  STARVE_LIMIT  4   cycles a buffered result may wait before stall is forced, >=1
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           asynchronous active-low reset
//  dec_rs1        in   ADDR_WIDTH  decode-stage source 1 (instr[19:15])
//  dec_rs2        in   ADDR_WIDTH  decode-stage source 2 (instr[24:20])
//  dec_rd         in   ADDR_WIDTH  decode-stage destination (instr[11:7])
//  dec_regwrite   in   1           decode instr writes rd via the pipeline
//  issue_valid    in   1           decode instr issues to the long-latency unit, dest dec_rd
//  stall          out  1           hold decode, suppress issue this cycle
//  pipe_we        in   1           pipeline writeback valid (never back-pressured)
//  pipe_rd        in   ADDR_WIDTH  pipeline writeback dest
//  pipe_wd        in   DATA_WIDTH  pipeline writeback data
//  lu_valid       in   1           long-unit result valid
//  lu_ready       out  1           result accepted when lu_valid & lu_ready
//  lu_rd          in   ADDR_WIDTH  long-unit result dest
//  lu_wd          in   DATA_WIDTH  long-unit result data
//  WE3            out  1           reg_file write enable
//  AD3            out  ADDR_WIDTH  reg_file write address
//  WD3            out  DATA_WIDTH  reg_file write data
// BEHAVIOUR
//  Reset (rst_n low, async): FIFO empty, pending=0, starve_cnt=0; WE3=0, AD3=0, WD3=0, stall=0, lu_ready=1.
//  Write-port select, combinational each cycle, fixed priority:
//   1) pipe_we -> pipeline write. 2) FIFO non-empty -> pop head. 3) lu_valid & FIFO empty -> bypass lu_* same cycle.
//   Long-unit result accepted but not written (priority 1 took the port) is pushed into the FIFO.
//  lu_ready = !full, or full & pop this cycle (same-cycle pop+push allowed; order preserved, head written first).
//  Any write with dest 0: WE3=0, but handshake/pop/scoreboard clear still occur.
//  Scoreboard pending[2**ADDR_WIDTH]: set pending[dec_rd] on issue_valid & !stall & dec_rd!=0;
//   clear pending[AD] when a long-unit result (FIFO pop or bypass) commits. Set and clear same index same cycle: set wins.
//   pending[0] always 0.
//  stall = pending[dec_rs1] | pending[dec_rs2] | ((dec_regwrite|issue_valid) & pending[dec_rd])
//   | (issue_valid & FIFO count >= FIFO_DEPTH-1) | (starve_cnt >= STARVE_LIMIT).
//  Issue count throttle is advisory; lu_ready remains the true flow control.
//  starve_cnt: +1 (saturating) each cycle FIFO non-empty and head not popped; 0 on pop or empty.
//   Forced stall inserts bubbles so pipe_we drops and the head drains.
//  Latency: bypass 0 cycles (write at next clk edge); buffered result >=1 cycle.
//  Reset mid-operation: buffered results and pending bits discarded; long unit is reset by the same rst_n.
//  Buffer overflow impossible by construction; push while full (lu_ready=0) is ignored.
// STRUCTURE
//  Package wb_pkg: wb_src_e {WB_NONE, WB_PIPE, WB_FIFO, WB_BYPASS}, wb_entry_t {rd, wd} struct.
//  Sub-module wb_fifo (DEPTH, wb_entry_t; push/pop/full/empty/count, async active-low reset).
//  Top: select mux, scoreboard register, starvation counter, stall logic.
// TESTING
//  Bypass: lu_valid, rd=5, wd=0xDEAD, pipe_we=0, FIFO empty -> WE3=1,AD3=5,WD3=0xDEAD same cycle; pending[5] cleared.
//  Collision: pipe_we rd=3 wd=1 with lu_valid rd=7 wd=2 -> cycle0 writes x3=1, x7 buffered; cycle1 writes x7=2.
//  Scoreboard: issue rd=9; next instr rs1=9 -> stall=1 until x9 commits, drops the cycle after.
//  Backpressure: pipe_we held high, 3 lu results -> 2 buffered, lu_ready=0 on third; stall rises after 4 cycles; drain in order.
//  x0: lu result rd=0 -> lu_ready=1, WE3=0, no pending change; issue rd=0 never stalls.
//  Reset mid-op: FIFO holding 2 entries, pending[4]=1, rst_n pulse -> all outputs at reset values, no further writes.

Source files
------------

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
//   Shared types for the register-file write-port arbiter.
//   wb_src_e   : which requester owns the write port in a given cycle.
//   wb_entry_t : one buffered long-unit result (destination + data), sized
//                for the default 32-bit / 32-register configuration.
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_PIPE,
        WB_FIFO,
        WB_BYPASS
    } wb_src_e;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   Small synchronous FIFO holding long-unit results that lost the write port.
//   Same-cycle push and pop are allowed, including when full: the head leaves
//   and the new entry takes the freed slot, so ordering is preserved.
//   A push while full without a pop is dropped.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and entry
//   pop        : remove head (ignored when empty)
//   dout       : current head entry (valid when !empty)
//   full/empty : occupancy flags
//   count      : number of stored entries
// ---------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  entry_t        din,
    input  logic          pop,
    output entry_t        dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    // A full FIFO can still accept when its head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Sole owner of the register-file write port (WE3/AD3/WD3). Shares it
//   between the in-order pipeline writeback and an out-of-band long-latency
//   unit, tracks registers whose long-unit result is still in flight, and
//   stalls decode on RAW/WAW hazards or write-port congestion.
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   dec_rs1/rs2/rd      : decode-stage register indices
//   dec_regwrite        : decode instr writes rd through the pipeline
//   issue_valid         : decode instr issues to the long unit (dest dec_rd)
//   stall               : hold decode / suppress issue this cycle
//   pipe_we/rd/wd       : pipeline writeback (highest priority, never held)
//   lu_valid/ready/rd/wd: long-unit result handshake
//   WE3/AD3/WD3         : register-file write port
// ---------------------------------------------------------------------------
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] dec_rs1,
    input  logic [ADDR_WIDTH-1:0] dec_rs2,
    input  logic [ADDR_WIDTH-1:0] dec_rd,
    input  logic                  dec_regwrite,
    input  logic                  issue_valid,
    output logic                  stall,
    input  logic                  pipe_we,
    input  logic [ADDR_WIDTH-1:0] pipe_rd,
    input  logic [DATA_WIDTH-1:0] pipe_wd,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [ADDR_WIDTH-1:0] lu_rd,
    input  logic [DATA_WIDTH-1:0] lu_wd,
    output logic                  WE3,
    output logic [ADDR_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0] WD3
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] wd;
    } entry_t;

    // ---------------------------------------------------------------
    // Result buffer
    // ---------------------------------------------------------------
    entry_t        head;
    entry_t        lu_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_push;
    logic          fifo_pop;

    assign lu_entry = '{rd: lu_rd, wd: lu_wd};

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (lu_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------------------------------------------------------
    // Write-port select: pipeline, then buffered head, then bypass.
    // Bypass is only legal with an empty buffer so results stay ordered.
    // ---------------------------------------------------------------
    wb_src_e               src;
    logic [ADDR_WIDTH-1:0] wr_rd;
    logic [DATA_WIDTH-1:0] wr_wd;
    logic                  ready_int;
    logic                  lu_commit;

    always_comb begin
        src = WB_NONE;
        if (pipe_we)          src = WB_PIPE;
        else if (!fifo_empty) src = WB_FIFO;
        else if (lu_valid)    src = WB_BYPASS;
    end

    always_comb begin
        wr_rd = '0;
        wr_wd = '0;
        case (src)
            WB_PIPE:   begin wr_rd = pipe_rd; wr_wd = pipe_wd; end
            WB_FIFO:   begin wr_rd = head.rd; wr_wd = head.wd; end
            WB_BYPASS: begin wr_rd = lu_rd;   wr_wd = lu_wd;   end
            default:   begin wr_rd = '0;      wr_wd = '0;      end
        endcase
    end

    assign fifo_pop  = (src == WB_FIFO);
    assign ready_int = ~fifo_full | fifo_pop;
    // Anything accepted that is not written directly goes into the buffer.
    assign fifo_push = lu_valid & ready_int & (src != WB_BYPASS);
    assign lu_commit = (src == WB_FIFO) | (src == WB_BYPASS);

    // ---------------------------------------------------------------
    // Starvation counter: how long the head has been waiting.
    // ---------------------------------------------------------------
    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // ---------------------------------------------------------------
    // Stall and scoreboard
    // ---------------------------------------------------------------
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic            stall_int;
    logic            issue_fire;

    // The count throttle keeps one slot free for the issuing op's result;
    // lu_ready is still the real flow control.
    assign stall_int = pending[dec_rs1]
                     | pending[dec_rs2]
                     | ((dec_regwrite | issue_valid) & pending[dec_rd])
                     | (issue_valid & (fifo_count >= CW'(FIFO_DEPTH - 1)))
                     | (starve_cnt >= SW'(STARVE_LIMIT));

    assign issue_fire = issue_valid & ~stall_int & (dec_rd != '0);

    // Clear first, then set, so a same-index set wins.
    always_comb begin
        pending_nxt = pending;
        if (lu_commit)  pending_nxt[wr_rd]  = 1'b0;
        if (issue_fire) pending_nxt[dec_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    // ---------------------------------------------------------------
    // Outputs are forced to their idle values while reset is asserted so
    // inputs still toggling from a mid-operation reset cannot leak out.
    // Writes to x0 still pop/handshake/clear but never enable the port.
    // ---------------------------------------------------------------
    assign WE3      = rst_n & (src != WB_NONE) & (wr_rd != '0);
    assign AD3      = rst_n ? wr_rd : '0;
    assign WD3      = rst_n ? wr_wd : '0;
    assign stall    = rst_n & stall_int;
    assign lu_ready = ~rst_n | ready_int;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int D = 2;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic        dec_regwrite = 1'b0, issue_valid = 1'b0;
    logic        stall;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_wd = '0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_wd = '0;
    logic        WE3;
    logic [4:0]  AD3;
    logic [31:0] WD3;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(D), .STARVE_LIMIT(L)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_regwrite(dec_regwrite), .issue_valid(issue_valid), .stall(stall),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wd(lu_wd),
        .WE3(WE3), .AD3(AD3), .WD3(WD3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: ordered queue of waiting results, a set of
    // in-flight destinations, and the head's waiting time.
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    ent_t q[$];
    bit   pend[32];
    int   starve = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                foreach (pend[i]) pend[i] = 1'b0;
                starve = 0;
                chk("m_rst_we", {31'd0, WE3}, 32'd0);
                chk("m_rst_stall", {31'd0, stall}, 32'd0);
                chk("m_rst_rdy", {31'd0, lu_ready}, 32'd1);
            end else begin
                int          n;
                bit          pop, byp, s, e_rdy, e_we, e_stall;
                logic [4:0]  r;
                logic [31:0] w;
                ent_t        h;
                n   = q.size();
                pop = !pipe_we && n > 0;
                byp = !pipe_we && n == 0 && lu_valid;
                e_rdy = (n < D) || pop;
                s = 1'b1; r = '0; w = '0;
                if (pipe_we)       begin r = pipe_rd; w = pipe_wd; end
                else if (n > 0)    begin r = q[0].rd; w = q[0].wd; end
                else if (lu_valid) begin r = lu_rd;   w = lu_wd;   end
                else               s = 1'b0;
                e_we = s && (r != 0);
                e_stall = pend[dec_rs1] || pend[dec_rs2]
                       || ((dec_regwrite || issue_valid) && pend[dec_rd])
                       || (issue_valid && n >= D - 1)
                       || (starve >= L);
                chk("m_we", {31'd0, WE3}, {31'd0, e_we});
                chk("m_rdy", {31'd0, lu_ready}, {31'd0, e_rdy});
                chk("m_stall", {31'd0, stall}, {31'd0, e_stall});
                if (e_we) begin
                    chk("m_ad", {27'd0, AD3}, {27'd0, r});
                    chk("m_wd", WD3, w);
                end
                // advance state to the next clock edge
                if (pop) begin
                    h = q.pop_front();
                    pend[h.rd] = 1'b0;
                end
                if (byp) pend[lu_rd] = 1'b0;
                if (lu_valid && e_rdy && !byp) q.push_back('{rd: lu_rd, wd: lu_wd});
                if (issue_valid && !e_stall && dec_rd != 0) pend[dec_rd] = 1'b1;
                if (pop || n == 0) starve = 0;
                else if (starve < L) starve++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
        dec_regwrite = 1'b0; issue_valid = 1'b0;
        pipe_we = 1'b0; pipe_rd = '0; pipe_wd = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_wd = '0;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_WE3", {31'd0, WE3}, 32'd0);
        chk("rst_AD3", {27'd0, AD3}, 32'd0);
        chk("rst_WD3", WD3, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Bypass with pending clear
        issue_valid = 1'b1; dec_rd = 5'd5;
        settle(); chk("issue5_stall", {31'd0, stall}, 32'd0);
        tick();
        idle(); dec_rs1 = 5'd5; lu_valid = 1'b1; lu_rd = 5'd5; lu_wd = 32'hDEAD;
        settle();
        chk("byp_stall", {31'd0, stall}, 32'd1);
        chk("byp_WE3", {31'd0, WE3}, 32'd1);
        chk("byp_AD3", {27'd0, AD3}, 32'd5);
        chk("byp_WD3", WD3, 32'hDEAD);
        tick();
        idle(); dec_rs1 = 5'd5;
        settle(); chk("byp_clr_stall", {31'd0, stall}, 32'd0);
        tick();

        // Collision: pipeline wins, long result buffered one cycle
        idle(); pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'd1;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_wd = 32'd2;
        settle();
        chk("col0_AD3", {27'd0, AD3}, 32'd3);
        chk("col0_WD3", WD3, 32'd1);
        chk("col0_rdy", {31'd0, lu_ready}, 32'd1);
        tick();
        idle();
        settle();
        chk("col1_WE3", {31'd0, WE3}, 32'd1);
        chk("col1_AD3", {27'd0, AD3}, 32'd7);
        chk("col1_WD3", WD3, 32'd2);
        tick();
        settle(); chk("col2_WE3", {31'd0, WE3}, 32'd0);
        tick();

        // Scoreboard RAW
        issue_valid = 1'b1; dec_rd = 5'd9;
        tick();
        idle(); dec_rs1 = 5'd9;
        settle(); chk("sb_stall0", {31'd0, stall}, 32'd1);
        tick();
        settle(); chk("sb_stall1", {31'd0, stall}, 32'd1);
        tick();
        lu_valid = 1'b1; lu_rd = 5'd9; lu_wd = 32'h99;
        settle(); chk("sb_commit_stall", {31'd0, stall}, 32'd1);
        tick();
        lu_valid = 1'b0;
        settle(); chk("sb_after_stall", {31'd0, stall}, 32'd0);
        tick();

        // Backpressure and starvation
        idle(); pipe_we = 1'b1; pipe_rd = 5'd1; pipe_wd = 32'h11;
        lu_valid = 1'b1; lu_rd = 5'd10; lu_wd = 32'hA0;
        settle(); chk("bp0_rdy", {31'd0, lu_ready}, 32'd1);
        tick();
        lu_rd = 5'd11; lu_wd = 32'hA1;
        settle(); chk("bp1_rdy", {31'd0, lu_ready}, 32'd1);
        tick();
        lu_rd = 5'd12; lu_wd = 32'hA2;
        settle(); chk("bp2_rdy", {31'd0, lu_ready}, 32'd0);
        tick(); tick();
        settle(); chk("bp4_stall", {31'd0, stall}, 32'd0);
        tick();
        settle(); chk("bp5_stall", {31'd0, stall}, 32'd1);
        tick();
        pipe_we = 1'b0;
        settle();
        chk("bp6_AD3", {27'd0, AD3}, 32'd10);
        chk("bp6_WD3", WD3, 32'hA0);
        chk("bp6_rdy", {31'd0, lu_ready}, 32'd1);
        tick();
        lu_valid = 1'b0;
        settle();
        chk("bp7_AD3", {27'd0, AD3}, 32'd11);
        chk("bp7_stall", {31'd0, stall}, 32'd0);
        tick();
        settle(); chk("bp8_AD3", {27'd0, AD3}, 32'd12);
        tick();
        settle(); chk("bp9_WE3", {31'd0, WE3}, 32'd0);
        tick();

        // x0 handling
        idle(); lu_valid = 1'b1; lu_rd = 5'd0; lu_wd = 32'h55;
        issue_valid = 1'b1; dec_rd = 5'd0;
        settle();
        chk("x0_rdy", {31'd0, lu_ready}, 32'd1);
        chk("x0_WE3", {31'd0, WE3}, 32'd0);
        chk("x0_issue_stall", {31'd0, stall}, 32'd0);
        tick();
        idle(); dec_regwrite = 1'b1; dec_rd = 5'd0;
        settle(); chk("x0_rw_stall", {31'd0, stall}, 32'd0);
        tick();

        // Reset mid-operation
        idle(); issue_valid = 1'b1; dec_rd = 5'd4;
        tick();
        idle(); pipe_we = 1'b1; pipe_rd = 5'd2; pipe_wd = 32'h22;
        lu_valid = 1'b1; lu_rd = 5'd4; lu_wd = 32'h44;
        tick();
        lu_wd = 32'h45;
        tick();
        lu_valid = 1'b0; dec_rs1 = 5'd4;
        settle(); chk("mid_stall", {31'd0, stall}, 32'd1);
        tick();
        rst_n = 1'b0;
        settle();
        chk("mid_rst_WE3", {31'd0, WE3}, 32'd0);
        chk("mid_rst_AD3", {27'd0, AD3}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_rdy", {31'd0, lu_ready}, 32'd1);
        tick();
        idle(); dec_rs1 = 5'd4; rst_n = 1'b1;
        settle();
        chk("post_WE3_0", {31'd0, WE3}, 32'd0);
        chk("post_stall", {31'd0, stall}, 32'd0);
        tick();
        settle(); chk("post_WE3_1", {31'd0, WE3}, 32'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
